// File: rtl/uart_rx_fifo_if.sv
// Byte stream from the UART receiver FIFO head to its consumer.
// Valid/ready: a byte moves on any cycle where rx_valid & rx_ready.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a small byte FIFO; byte is visible 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after the start edge.
// Consumer backpressure holds bytes in the FIFO; uart_rts throttles the host near full, and a byte arriving when full is dropped with an overrun pulse.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic            sample_clock,
  input  logic            key,
  input  logic            uart_rx,
  output logic            uart_rts,
  output logic            frame_error,
  output logic            overrun,
  uart_rx_fifo_if.master  rx_bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int NW = PW + 1;

  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [NW-1:0] FULL     = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] RTS_ON   = NW'(FIFO_DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  logic          rx_meta;
  logic          rxs;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [NW-1:0] count;
  logic [NW-1:0] next_count;

  logic stop_hit;
  logic good_stop;
  logic pop;
  logic push;

  // Idle-high line: synchroniser resets to 1 so reset release never looks like a start bit.
  always_ff @(posedge sample_clock or negedge key) begin
    if (!key) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  assign stop_hit  = (state == STOP) && (cnt == BIT_END);
  assign good_stop = stop_hit && rxs;

  always_ff @(posedge sample_clock or negedge key) begin
    if (!key) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= stop_hit && !rxs;
      case (state)
        IDLE: begin
          if (!rxs) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == HALF_END) begin
            if (!rxs) begin
              state <= DATA;
              cnt   <= '0;
              idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == BIT_END) begin
            shreg[idx] <= rxs;
            cnt        <= '0;
            if (idx == 3'd7) begin
              state <= STOP;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == BIT_END) begin
            cnt   <= '0;
            state <= rxs ? IDLE : WAIT_HIGH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_HIGH: begin
          // A held-low break must not be read as a stream of zero frames.
          if (rxs) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop  = (count != '0) && rx_bus.rx_ready;
  assign push = good_stop && ((count != FULL) || pop);

  always_comb begin
    next_count = count;
    if (push && !pop) begin
      next_count = count + NW'(1);
    end else if (!push && pop) begin
      next_count = count - NW'(1);
    end
  end

  always_ff @(posedge sample_clock or negedge key) begin
    if (!key) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overrun  <= 1'b0;
      uart_rts <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[tail] <= shreg;
        tail      <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count    <= next_count;
      overrun  <= good_stop && (count == FULL) && !pop;
      uart_rts <= (next_count >= RTS_ON);
    end
  end

  assign rx_bus.rx_data  = mem[head];
  assign rx_bus.rx_valid = (count != '0);

endmodule
